scene_rom_arbiter: RTL and testbench
====================================

// Module: scene_rom_arbiter
// PURPOSE
//  Shares read port A of the 32-bit x 128K-word scene ROM between NUM_REQ requesters
//   (ray traversal units, triangle/BVH fetch, debug readout).
//  Each requester issues one burst at a time: start address + length (1..8 words).
//  The block grants one burst at a time, drives the ROM address and read enable, and
//   tracks the ROM read latency. Returned words are routed back to the owning requester.
//  Sits between the compute engines and the ROM instance, all on the 50 MHz system clock.
// PARAMETERS
//  NUM_REQ   4   number of requesters, 2..8
//  ROM_LAT   2   cycles from rom_addr/rom_rden sampled to rom_q valid (1..4)
// PORTS
//  clk        in   1           system clock (single clock domain)
//  reset      in   1           synchronous, active-high reset
//  req_valid  in   NUM_REQ     burst request pending, per requester
//  req_addr   in   NUM_REQ*17  burst start word address, packed [i*17 +: 17]
//  req_len    in   NUM_REQ*3   beats-1 (0 = 1 word, 7 = 8 words), packed [i*3 +: 3]
//  req_ready  out  NUM_REQ     one-hot accept; transfer = req_valid[i] & req_ready[i]
//  rom_addr   out  17          ROM port A address
//  rom_rden   out  1           ROM port A read enable
//  rom_q      in   32          ROM port A read data
//  rsp_valid  out  NUM_REQ     one-hot: rsp_data belongs to requester i this cycle
//  rsp_data   out  32          returned word, shared bus
//  rsp_last   out  1           final word of the burst
//  busy       out  1           burst issuing or reads still in flight
// BEHAVIOUR
//  Reset: FSM=IDLE; req_ready=0, rom_rden=0, rom_addr=0, rsp_valid=0, rsp_data=0,
//   rsp_last=0, busy=0; RR pointer=0; latency pipeline cleared.
//  FSM IDLE: if any req_valid, assert req_ready for exactly one winner (combinational
//   from req_valid and the pointer). On handshake, latch addr, len and index -> ISSUE.
//   No req_valid: stay in IDLE with req_ready=0.
//  FSM ISSUE: each cycle drive rom_rden=1 and rom_addr=base+beat; beat counts 0..len.
//   After beat==len is issued -> IDLE. req_ready=0 throughout ISSUE.
//  Throughput: burst of n words occupies n ISSUE cycles plus 1 IDLE grant cycle.
//   Consecutive bursts may overlap in the return pipeline.
//  Return pipeline: ROM_LAT-deep shift register of {valid, idx, last} per issued beat.
//   At the output: rsp_valid[idx]=1, rsp_data=rom_q, rsp_last=last.
//   Data for the beat issued at cycle t appears at t+ROM_LAT. Order within and across
//   bursts is preserved.
//  No response backpressure: requesters must accept every rsp_valid beat.
//  Address arithmetic: 17-bit unsigned, base+beat wraps 17'h1FFFF -> 17'h00000.
//  Round-robin: after each grant, pointer = winner+1 (mod NUM_REQ). Search starts at
//   the pointer. The same requester cannot win twice while another is waiting.
//  Simultaneous: the final-beat issue cycle and the new grant are never the same cycle.
//   A new grant happens in the IDLE cycle that follows.
//  req_valid dropped before handshake: no grant, nothing recorded.
//  busy = (state!=IDLE) | any pipeline valid.
//  Reset mid-burst: issue aborts, pipeline flushed; no rsp_valid in the cycle after
//   reset is sampled. Partially returned bursts are never completed.
//  rsp_data holds its last value when rsp_valid=0. rom_addr holds when rom_rden=0.
// CONFIGURATION
//  SCENE_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, no pointer state.
//   Used to starve the debug port behind the traversal units.
//  SCENE_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
// STRUCTURE
//  Package scene_rom_pkg:
//   SCENE_ADDR_W=17, SCENE_DATA_W=32, BURST_LEN_W=3
//   typedefs scene_addr_t, scene_word_t, burst_len_t
//   typedef enum arb_state_t {IDLE, ISSUE}
//  Sub-module rr_arbiter #(N): req[N], advance -> grant one-hot[N].
//   Holds the pointer; the fixed-priority variant is selected by the macro.
//  Top holds the FSM, beat counter, address adder and latency shift register.
// TESTING (ROM model: addr->q = {15'h0, addr}, latency ROM_LAT=2)
//  1 Req0 addr=17'h00010 len=0 -> req_ready[0] same cycle.
//    One rsp_valid[0], data=32'h10, rsp_last=1, 3 cycles after handshake.
//  2 Req2 addr=17'h00100 len=7 -> 8 back-to-back rsp_valid[2], data 0x100..0x107.
//    rsp_last only on 0x107; busy drops the cycle after.
//  3 Req0,1,3 all valid with len=1 -> grants 0,1,3,0,...
//    Each requester gets exactly its 2 words, in grant order.
//  4 Req1 addr=17'h1FFFE len=3 -> data 0x1FFFE,0x1FFFF,0x0,0x1.
//  5 Reset pulsed on the 3rd ISSUE cycle of a len=7 burst.
//    -> all outputs at reset values next cycle, no further rsp_valid.
//    A new req then completes normally.
//  6 With SCENE_ARB_FIXED_PRIO_EN, req0 and req3 held valid -> req3 never granted.
//    Without the macro they alternate.

Source files
------------

// File: rtl/scene_rom_pkg.sv
// Shared widths, types and FSM encoding for the scene ROM port-A arbiter.
package scene_rom_pkg;

    localparam int SCENE_ADDR_W = 17;
    localparam int SCENE_DATA_W = 32;
    localparam int BURST_LEN_W  = 3;

    // Requester index is carried through the return pipeline; 3 bits covers 2..8 requesters.
    localparam int REQ_IDX_W    = 3;

    typedef logic [SCENE_ADDR_W-1:0] scene_addr_t;
    typedef logic [SCENE_DATA_W-1:0] scene_word_t;
    typedef logic [BURST_LEN_W-1:0]  burst_len_t;
    typedef logic [REQ_IDX_W-1:0]    req_idx_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } arb_state_t;

    // One entry of the read-latency pipeline: which requester owns the word and
    // whether it closes the burst.
    typedef struct packed {
        logic     valid;
        req_idx_t idx;
        logic     last;
    } ret_beat_t;

endpackage

// File: rtl/scene_rom_arbiter_if.sv
// Bundle of requester, ROM port-A and response signals around the scene ROM arbiter.
// slave  : the arbiter itself.
// master : the environment (requesters + ROM) that drives requests and read data.
interface scene_rom_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import scene_rom_pkg::*;

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*SCENE_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*BURST_LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]              req_ready;
    scene_addr_t                     rom_addr;
    logic                            rom_rden;
    scene_word_t                     rom_q;
    logic [NUM_REQ-1:0]              rsp_valid;
    scene_word_t                     rsp_data;
    logic                            rsp_last;
    logic                            busy;

    modport slave (
        input  req_valid, req_addr, req_len, rom_q,
        output req_ready, rom_addr, rom_rden, rsp_valid, rsp_data, rsp_last, busy
    );

    modport master (
        output req_valid, req_addr, req_len, rom_q,
        input  req_ready, rom_addr, rom_rden, rsp_valid, rsp_data, rsp_last, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// One-hot request arbiter for the scene ROM port.
// Default: round-robin, search starts at the pointer, pointer = winner+1 after a grant.
// SCENE_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, no pointer state.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

`ifdef SCENE_ARB_FIXED_PRIO_EN

    // Pointer-free variant keeps the same port list; these inputs are intentionally idle.
    logic unused_ok;
    assign unused_ok = ^{clk, reset, advance_i};

    // Lowest-index requester wins; scanning downward leaves the lowest hit in place.
    always_comb begin
        grant_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
            end
        end
    end

`else

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] slot;
    logic             found;
    int               pos;

    // Circular search from the pointer; first pending requester wins.
    always_comb begin
        grant_o = '0;
        winner  = '0;
        slot    = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            slot = IDX_W'(pos);
            if (!found && req_i[slot]) begin
                grant_o[slot] = 1'b1;
                winner        = slot;
                found         = 1'b1;
            end
        end
        ptr_d = (winner == IDX_W'(N - 1)) ? '0 : winner + 1'b1;
    end

    // Pointer moves past the winner only when the grant is actually taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/scene_rom_arbiter.sv
// Scene ROM port-A arbiter: grants one burst at a time, issues one ROM read per
// cycle, and routes returned words back to the owning requester after ROM_LAT cycles.
// Arbitration policy is chosen in rr_arbiter by SCENE_ARB_FIXED_PRIO_EN.
module scene_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ROM_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    scene_rom_arbiter_if.slave  bus
);
    import scene_rom_pkg::*;

    arb_state_t   state_q, state_d;
    scene_addr_t  base_q, base_d;
    burst_len_t   len_q, len_d;
    burst_len_t   beat_q, beat_d;
    req_idx_t     idx_q, idx_d;
    scene_addr_t  addr_hold_q;
    scene_word_t  rsp_data_q;
    ret_beat_t    pipe_q [ROM_LAT];

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] req_ready;
    logic               handshake;
    logic               rom_rden;
    logic               issue_last;
    scene_addr_t        issue_addr;
    scene_addr_t        sel_addr;
    burst_len_t         sel_len;
    req_idx_t           sel_idx;
    ret_beat_t          out_beat;
    logic               pipe_any;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (bus.req_valid),
        .advance_i (handshake),
        .grant_o   (grant)
    );

    // Pick the winner's address, length and index off the packed request buses.
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        sel_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = bus.req_addr[i*SCENE_ADDR_W +: SCENE_ADDR_W];
                sel_len  = bus.req_len[i*BURST_LEN_W +: BURST_LEN_W];
                sel_idx  = req_idx_t'(i);
            end
        end
    end

    // FSM next state, grant handshake and ROM issue controls.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        beat_d     = beat_q;
        idx_d      = idx_q;
        req_ready  = '0;
        handshake  = 1'b0;
        rom_rden   = 1'b0;
        issue_last = 1'b0;
        issue_addr = base_q + scene_addr_t'(beat_q);
        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (|bus.req_valid) begin
                    handshake = 1'b1;
                    base_d    = sel_addr;
                    len_d     = sel_len;
                    idx_d     = sel_idx;
                    beat_d    = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                rom_rden = 1'b1;
                if (beat_q == len_q) begin
                    issue_last = 1'b1;
                    state_d    = IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, burst context and held ROM address.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            idx_q       <= '0;
            addr_hold_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            if (rom_rden) begin
                addr_hold_q <= issue_addr;
            end
        end
    end

    // Read-latency pipeline: one entry per cycle, tagged with owner and last flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this pipeline is reset (unlike a data RAM) because a stale valid bit would emit a phantom response.
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: rom_rden, idx: idx_q, last: issue_last};
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Keep the last returned word so rsp_data is stable between beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data_q <= '0;
        end else if (out_beat.valid) begin
            rsp_data_q <= bus.rom_q;
        end
    end

    // Any beat still waiting for ROM data keeps the block busy.
    always_comb begin
        pipe_any = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) begin
            pipe_any = pipe_any | pipe_q[i].valid;
        end
    end

    assign out_beat      = pipe_q[ROM_LAT-1];
    assign bus.req_ready = req_ready;
    assign bus.rom_rden  = rom_rden;
    assign bus.rom_addr  = rom_rden ? issue_addr : addr_hold_q;
    assign bus.rsp_valid = out_beat.valid ? (NUM_REQ'(1) << out_beat.idx) : '0;
    assign bus.rsp_data  = out_beat.valid ? bus.rom_q : rsp_data_q;
    assign bus.rsp_last  = out_beat.valid & out_beat.last;
    assign bus.busy      = (state_q != IDLE) | pipe_any;

endmodule

// File: tb/tb_scene_rom_arbiter.sv
// Self-checking bench for scene_rom_arbiter: directed bursts, mid-burst reset,
// arbitration fairness and a randomized phase, all compared cycle by cycle against
// a schedule-based reference model of grants, ROM reads and returned words.
module tb_scene_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ROM_LAT = 2;
    localparam int MAXC    = 8192;

    logic clk;
    logic reset;

    scene_rom_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    scene_rom_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester stimulus, packed onto the interface buses.
    logic        v_a [NUM_REQ];
    logic [16:0] a_a [NUM_REQ];
    logic [2:0]  l_a [NUM_REQ];

    always_comb begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]          = v_a[i];
            bus.req_addr[i*17 +: 17]  = a_a[i];
            bus.req_len[i*3 +: 3]     = l_a[i];
        end
    end

    // ROM model: q = {15'h0, addr}, ROM_LAT register stages.
    logic [31:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        if (bus.rom_rden) rom_pipe[0] <= {15'h0, bus.rom_addr};
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.rom_q = rom_pipe[ROM_LAT-1];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: expected activity per cycle, filled in at grant time.
    bit          exp_rden  [MAXC];
    logic [16:0] exp_addr  [MAXC];
    bit          exp_rv    [MAXC];
    int          exp_ridx  [MAXC];
    logic [31:0] exp_rdata [MAXC];
    bit          exp_rlast [MAXC];
    int          m_ptr        = 0;
    int          m_next_grant = 0;
    logic [16:0] m_last_addr  = '0;
    logic [31:0] m_last_data  = '0;
    bit          mon_en       = 1'b0;
    bit          hs_seen [NUM_REQ];
    int          hs_cnt  [NUM_REQ];

    function automatic int pick_winner(input logic [NUM_REQ-1:0] v);
        int w;
        w = -1;
`ifdef SCENE_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) if (v[i]) w = i;
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) if (v[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
`endif
        return w;
    endfunction

    always @(negedge clk) begin : monitor
        logic [NUM_REQ-1:0] e_ready;
        logic [NUM_REQ-1:0] e_rv;
        logic               e_busy;
        int                 win;
        win = -1;
        if (cyc >= m_next_grant && |bus.req_valid) win = pick_winner(bus.req_valid);
        e_ready = (win >= 0) ? NUM_REQ'(1) << win : '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hs_seen[i] = bus.req_valid[i] & bus.req_ready[i];
            if (mon_en && !reset && hs_seen[i]) hs_cnt[i]++;
        end
        if (mon_en) begin
            check("req_ready", 32'(bus.req_ready), 32'(e_ready));
            check("rom_rden", 32'(bus.rom_rden), 32'(exp_rden[cyc]));
            if (exp_rden[cyc]) m_last_addr = exp_addr[cyc];
            check("rom_addr", 32'(bus.rom_addr), 32'(m_last_addr));
            e_rv = exp_rv[cyc] ? NUM_REQ'(1) << exp_ridx[cyc] : '0;
            if (exp_rv[cyc]) m_last_data = exp_rdata[cyc];
            check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
            check("rsp_data", bus.rsp_data, m_last_data);
            check("rsp_last", 32'(bus.rsp_last), 32'(exp_rv[cyc] & exp_rlast[cyc]));
            e_busy = exp_rden[cyc];
            for (int k = 0; k < ROM_LAT; k++) e_busy = e_busy | exp_rv[cyc + k];
            check("busy", 32'(bus.busy), 32'(e_busy));
        end
        if (reset) begin
            for (int r = cyc + 1; r < cyc + 32 && r < MAXC; r++) begin
                exp_rden[r] = 1'b0;
                exp_rv[r]   = 1'b0;
            end
            m_ptr        = 0;
            m_next_grant = cyc + 1;
            m_last_addr  = '0;
            m_last_data  = '0;
            mon_en       = 1'b1;
        end else if (win >= 0) begin
            for (int k = 0; k <= int'(l_a[win]); k++) begin
                int i;
                int r;
                i = cyc + 1 + k;
                r = i + ROM_LAT;
                if (r < MAXC) begin
                    exp_rden[i]  = 1'b1;
                    exp_addr[i]  = a_a[win] + 17'(k);
                    exp_rv[r]    = 1'b1;
                    exp_ridx[r]  = win;
                    exp_rdata[r] = {15'h0, a_a[win] + 17'(k)};
                    exp_rlast[r] = (k == int'(l_a[win]));
                end
            end
            m_ptr        = (win + 1) % NUM_REQ;
            m_next_grant = cyc + 2 + int'(l_a[win]);
        end
        cyc++;
    end

    function automatic logic [16:0] rand_addr();
        if ($urandom_range(3) == 0) return 17'h1FFF8 + 17'($urandom_range(7));
        return 17'($urandom);
    endfunction

    task automatic do_burst(input int i, input logic [16:0] a, input logic [2:0] l);
        int t;
        t = 0;
        @(posedge clk); #1;
        v_a[i] = 1'b1;
        a_a[i] = a;
        l_a[i] = l;
        do begin
            @(negedge clk);
            t++;
        end while (!hs_seen[i] && t < 50);
        check("handshake", 32'(hs_seen[i]), 32'd1);
        @(posedge clk); #1;
        v_a[i] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while (bus.busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic traffic(input int ncyc, input bit [7:0] mask, input int p_new,
                           input int p_drop, input int budget, input int flen);
        int left [NUM_REQ];
        for (int i = 0; i < NUM_REQ; i++) left[i] = budget;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (v_a[i] && hs_seen[i]) v_a[i] = 1'b0;
                else if (v_a[i] && int'($urandom_range(99)) < p_drop) v_a[i] = 1'b0;
                if (!v_a[i] && mask[i] && left[i] > 0 && int'($urandom_range(99)) < p_new) begin
                    left[i]--;
                    v_a[i] = 1'b1;
                    a_a[i] = rand_addr();
                    l_a[i] = (flen < 0) ? 3'($urandom_range(7)) : 3'(flen);
                end
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < NUM_REQ; i++) v_a[i] = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int h0;
        int h3;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_a[i]    = 1'b0;
            a_a[i]    = '0;
            l_a[i]    = '0;
            hs_cnt[i] = 0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single-word burst, then a full 8-word burst, then an address-wrapping burst.
        do_burst(0, 17'h00010, 3'd0);
        drain();
        do_burst(2, 17'h00100, 3'd7);
        drain();
        do_burst(1, 17'h1FFFE, 3'd3);
        drain();

        // Reset lands on the third ISSUE cycle of an 8-word burst.
        do_burst(2, 17'h00200, 3'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_rsp", 32'(bus.rsp_valid), 32'd0);
        drain();

        // Requesters 0, 1, 3 each with two 2-word bursts.
        traffic(30, 8'b0000_1011, 100, 0, 2, 1);
        drain();

        // Requesters 0 and 3 held valid continuously.
        h0 = hs_cnt[0];
        h3 = hs_cnt[3];
        traffic(60, 8'b0000_1001, 100, 0, 1000, 0);
        drain();
`ifdef SCENE_ARB_FIXED_PRIO_EN
        check("starve_req3", 32'(hs_cnt[3] - h3), 32'd0);
        check("prio_req0_active", 32'(hs_cnt[0] - h0 > 10), 32'd1);
`else
        check("alternate_req3_active", 32'(hs_cnt[3] - h3 > 10), 32'd1);
        check("alternate_balance", 32'((hs_cnt[0] - h0) - (hs_cnt[3] - h3) <= 1 &&
                                       (hs_cnt[3] - h3) - (hs_cnt[0] - h0) <= 1), 32'd1);
`endif

        // Randomized mixed traffic with occasional withdrawn requests.
        traffic(1500, 8'b0000_1111, 30, 5, 100000, -1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
